// File: rtl/counter_ctrl_if.sv
// Configuration handshake between the control plane and counter_ctrl.
// The master offers a timer setup and the slave accepts it with cfg_ready.
interface counter_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_value;
  logic        cfg_up;
  logic        cfg_periodic;

  modport master (
    output cfg_valid, cfg_value, cfg_up, cfg_periodic,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_value, cfg_up, cfg_periodic,
    output cfg_ready
  );
endinterface

// File: rtl/counter_ctrl.sv
// Timer sequencer for the free-running up/down counter: loads it, watches its
// interrupt, then re-arms or stops, and reports a sticky irq, expiry count and overrun.
module counter_ctrl #(
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned EXP_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  counter_ctrl_if.slave     cfg,
  input  logic              stop,
  input  logic              irq_in,
  input  logic              irq_ack,
  output logic              ctr_load,
  output logic              ctr_up_down,
  output logic [31:0]       ctr_load_value,
  output logic              irq_out,
  output logic              overrun,
  output logic              busy,
  output logic [EXP_W-1:0]  expire_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  logic [1:0]       state_q,    state_d;
  logic [3:0]       load_cnt_q, load_cnt_d;
  logic             first_q,    first_d;
  logic [31:0]      value_q,    value_d;
  logic             up_q,       up_d;
  logic             periodic_q, periodic_d;
  logic             irq_q,      irq_d;
  logic             ovr_q,      ovr_d;
  logic [EXP_W-1:0] exp_q,      exp_d;
  logic             load_q,     load_d;
  logic             busy_q,     busy_d;
  logic             expire;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    first_d    = first_q;
    value_d    = value_q;
    up_d       = up_q;
    periodic_d = periodic_q;
    irq_d      = irq_q;
    ovr_d      = ovr_q;
    exp_d      = exp_q;
    expire     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg.cfg_valid) begin
          state_d    = LOAD;
          value_d    = cfg.cfg_value;
          up_d       = cfg.cfg_up;
          periodic_d = cfg.cfg_periodic;
          exp_d      = '0;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (load_cnt_q == LOAD_LAST) begin
          state_d = RUN;
          first_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q + 4'd1;
        end
      end
      RUN: begin
        // The first RUN cycle may still see a pulse from the pre-load count.
        if (stop) begin
          state_d = IDLE;
        end else if (first_q) begin
          first_d = 1'b0;
        end else if (irq_in) begin
          expire     = 1'b1;
          state_d    = periodic_q ? LOAD : IDLE;
          load_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) ovr_d = 1'b1;
      if (exp_q != '1) exp_d = exp_q + 1'b1;
    end

    load_d = (state_d == LOAD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      first_q    <= 1'b0;
      value_q    <= '0;
      up_q       <= 1'b1;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      exp_q      <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      first_q    <= first_d;
      value_q    <= value_d;
      up_q       <= up_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
      exp_q      <= exp_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg.cfg_ready   = (state_q == IDLE);
  assign ctr_load        = load_q;
  assign ctr_up_down     = up_q;
  assign ctr_load_value  = value_q;
  assign irq_out         = irq_q;
  assign overrun         = ovr_q;
  assign busy            = busy_q;
  assign expire_cnt      = exp_q;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer that owns the load/direction side of the free-running 32-bit up/down counter and consumes its interrupt pulse. Accepts a timer configuration over a valid/ready handshake, drives the counter's two-stage load, then monitors the counter interrupt and either re-arms (periodic) or stops (one-shot). Presents a sticky, acknowledgeable interrupt plus an expiry count and an overrun flag to the control plane of the undistort pipeline.

Parameters:
LOAD_CYCLES, 2, consecutive cycles ctr_load is held so the value passes the counter's load_reg stage into count (legal 2..15)
EXP_W, 16, width of expire_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready
cfg_value  input  32  value to load into counter
cfg_up  input  1  1 = count up, 0 = count down
cfg_periodic  input  1  1 = reload after every expiry, 0 = one-shot
stop  input  1  abort current timer, return to IDLE
irq_in  input  1  interrupt pulse from counter (count reached 32'hFFFFFFFF)
irq_ack  input  1  clears irq_out and overrun
ctr_load  output  1  counter load strobe
ctr_up_down  output  1  counter direction
ctr_load_value  output  32  counter load value
irq_out  output  1  sticky interrupt to software
overrun  output  1  sticky: expiry arrived while irq_out pending and unacked
busy  output  1  1 in LOAD or RUN
expire_cnt  output  EXP_W  expiries since last configuration, saturating

Behaviour:
- Reset (async, immediate): state IDLE; ctr_load=0, ctr_up_down=1, ctr_load_value=0, irq_out=0, overrun=0, busy=0, expire_cnt=0; latched cfg fields cleared. cfg_ready=1 once out of reset.
- All outputs registered except cfg_ready = (state==IDLE).
- States: IDLE, LOAD, RUN.
- IDLE: on cfg_valid&&cfg_ready latch value/up/periodic, clear expire_cnt, go LOAD. cfg ignored in all other states (cfg_ready=0).
- LOAD: ctr_load=1 for exactly LOAD_CYCLES consecutive cycles starting the cycle after acceptance; ctr_load_value and ctr_up_down = latched fields, stable throughout. Then RUN with ctr_load=0. irq_in ignored in LOAD.
- RUN: irq_in ignored in the first RUN cycle (stale pulse from pre-load count). Afterwards irq_in=1 is an expiry:
  - expire_cnt +1, saturates at all-ones (no wrap).
  - irq_out <= 1; if irq_out already 1 and irq_ack=0 that cycle, overrun <= 1.
  - periodic: next state LOAD (reload same latched value, full LOAD_CYCLES). one-shot: next state IDLE.
- ctr_up_down holds latched direction in IDLE after a run (counter keeps free-running; no enable exists).
- stop=1 in LOAD or RUN: next state IDLE, ctr_load=0 next cycle; stop beats a same-cycle irq_in (expiry not counted, irq_out unchanged). stop in IDLE: no effect.
- irq_ack=1: clears irq_out and overrun; same-cycle expiry wins: irq_out stays 1, overrun stays 0 (cleared).
- Reset mid-LOAD/RUN: all outputs to reset values immediately, ctr_load drops asynchronously.

Test Plan:
- Reset then cfg_valid=1, value=32'hFFFFFFF0, up=1, periodic=0 -> cfg_ready drops, ctr_load high exactly 2 cycles, ctr_load_value=32'hFFFFFFF0, busy=1; with counter model irq_in pulses once -> irq_out=1, expire_cnt=1, state IDLE, cfg_ready=1.
- Periodic, up, value=32'hFFFFFFFC with counter model -> after each irq_in, ctr_load re-asserts 2 cycles; after 3 expiries expire_cnt=3, overrun=1 (no ack given), irq_out=1.
- irq_ack asserted in same cycle as an expiry -> irq_out stays 1, overrun=0; ack next cycle with no expiry -> irq_out=0.
- irq_in forced high in every LOAD cycle and first RUN cycle -> no expiry counted, irq_out stays 0.
- stop and irq_in high in same RUN cycle -> IDLE next cycle, expire_cnt unchanged, irq_out=0, ctr_load=0.
- Assert rst during LOAD (ctr_load=1) -> ctr_load, busy, irq_out, expire_cnt go 0 before next clock edge; ctr_up_down=1; cfg_ready=1 after release.
